// File: rtl/player_input_encoder.sv
// Debounces q/w/a/s key levels and emits one tile_valid pulse per accepted single-key press, plus a no-press timeout.
// Latency: tile_valid rises DEBOUNCE_CYCLES+2 cycles after a lone key first appears at the inputs.
// Backpressure: none; enable low returns the block to IDLE on the next edge and suppresses any pulse.
module player_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       q,
  input  logic       w,
  input  logic       a,
  input  logic       s,
  output logic [1:0] tile,
  output logic       tile_valid,
  output logic       timeout,
  output logic       ready,
  output logic       key_held
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_DEBOUNCE_PRESS,
    ST_WAIT_RELEASE,
    ST_DEBOUNCE_RELEASE,
    ST_TIMED_OUT
  } state_t;

  state_t          r_state;
  logic [3:0]      r_k;      // {s,a,w,q}, registered once
  logic [3:0]      r_pat;    // pattern being debounced
  logic [DW-1:0]   r_dcnt;
  logic [TW-1:0]   r_tcnt;
  logic [1:0]      r_tile;
  logic            r_tile_valid;
  logic            r_timeout;
  logic            r_ready;
  logic            r_key_held;

  logic            w_one_hot;
  logic            w_tout;
  logic [1:0]      w_pat_code;

  assign w_one_hot = (r_k != 4'd0) && ((r_k & (r_k - 4'd1)) == 4'd0);
  assign w_tout    = (r_tcnt == TCNT_LAST);

  // Map the latched one-hot pattern to its tile code (q=0, w=1, a=2, s=3).
  always_comb begin
    w_pat_code = 2'd0;
    case (r_pat)
      4'b0010: w_pat_code = 2'd1;
      4'b0100: w_pat_code = 2'd2;
      4'b1000: w_pat_code = 2'd3;
      default: w_pat_code = 2'd0;
    endcase
  end

  // Input register, press/release FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= 4'd0;
      r_pat        <= 4'd0;
      r_dcnt       <= '0;
      r_tcnt       <= '0;
      r_tile       <= 2'd0;
      r_tile_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_ready      <= 1'b0;
      r_key_held   <= 1'b0;
    end else begin
      r_k          <= {s, a, w, q};
      r_tile_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_ready      <= (r_state == ST_WAIT_PRESS);
      r_key_held   <= (r_state == ST_WAIT_RELEASE) || (r_state == ST_DEBOUNCE_RELEASE);
      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tcnt  <= '0;
            r_state <= ST_WAIT_PRESS;
          end
          ST_WAIT_PRESS: begin
            if (w_tout) begin
              r_timeout <= 1'b1;
              r_state   <= ST_TIMED_OUT;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
              if (w_one_hot) begin
                r_pat   <= r_k;
                r_dcnt  <= '0;
                r_state <= ST_DEBOUNCE_PRESS;
              end
            end
          end
          ST_DEBOUNCE_PRESS: begin
            // Acceptance is checked before timeout so it wins a tie.
            if ((r_k == r_pat) && (r_dcnt == DCNT_LAST)) begin
              r_tile       <= w_pat_code;
              r_tile_valid <= 1'b1;
              r_state      <= ST_WAIT_RELEASE;
            end else if (w_tout) begin
              r_timeout <= 1'b1;
              r_state   <= ST_TIMED_OUT;
            end else begin
              // tcnt keeps running across aborted attempts.
              r_tcnt <= r_tcnt + TW'(1);
              if (r_k != r_pat) r_state <= ST_WAIT_PRESS;
              else              r_dcnt  <= r_dcnt + DW'(1);
            end
          end
          ST_WAIT_RELEASE: begin
            if (r_k == 4'd0) begin
              r_dcnt  <= '0;
              r_state <= ST_DEBOUNCE_RELEASE;
            end
          end
          ST_DEBOUNCE_RELEASE: begin
            // Any key during release debounce restarts the wait, so a bounce or long hold cannot re-trigger.
            if (r_k != 4'd0) begin
              r_state <= ST_WAIT_RELEASE;
            end else if (r_dcnt == DCNT_LAST) begin
              r_tcnt  <= '0;
              r_state <= ST_WAIT_PRESS;
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          ST_TIMED_OUT: r_state <= ST_TIMED_OUT;
          default:      r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tile       = r_tile;
  assign tile_valid = r_tile_valid;
  assign timeout    = r_timeout;
  assign ready      = r_ready;
  assign key_held   = r_key_held;

endmodule

// File: tb/tb_player_input_encoder.sv
// Bench for player_input_encoder with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
// Expected pulses (kind, tile, cycle) are queued as stimulus is driven and matched when the DUT pulses.
// Any pulse with no queued expectation, or expectation left unmatched, is reported.
module tb_player_input_encoder;

  localparam int DC = 4;
  localparam int TC = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       q = 1'b0, w = 1'b0, a = 1'b0, s = 1'b0;
  logic [1:0] tile;
  logic       tile_valid, timeout, ready, key_held;

  player_input_encoder #(.DEBOUNCE_CYCLES(DC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .q(q), .w(w), .a(a), .s(s),
    .tile(tile), .tile_valid(tile_valid), .timeout(timeout),
    .ready(ready), .key_held(key_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = tile_valid, 1 = timeout
    int tile;
    int cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int t, input int c);
    exp_t e;
    e.kind = kind; e.tile = t; e.cyc = c;
    sb.push_back(e);
  endtask

  // Leaves the DUT freshly in WAIT_PRESS with tcnt near zero.
  task automatic rearm();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(3);
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && (tile_valid || timeout)) begin
      chk("exclusive", int'(tile_valid && timeout), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'({tile_valid, timeout}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", int'(timeout), e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == 0) chk("pulse_tile", int'(tile), e.tile);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int c0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_tile", int'(tile), 0);
    chk("rst_tile_valid", int'(tile_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_key_held", int'(key_held), 0);
    reset = 1'b0;
    enable = 1'b1;
    tick(3);
    chk("ready_in_wait", int'(ready), 1);

    // Clean press of 'a' for 20 cycles
    rearm();
    c0 = cyc;
    a = 1'b1;
    push(0, 2, c0 + DC + 2);
    tick(7);
    chk("clean_key_held", int'(key_held), 1);
    chk("clean_tile_hold", int'(tile), 2);
    tick(13);
    a = 1'b0;
    tick(4);
    chk("clean_held_after_rel", int'(key_held), 1);
    tick(3);
    chk("clean_held_cleared", int'(key_held), 0);
    chk("clean_ready_again", int'(ready), 1);
    chk("clean_drain", sb.size(), 0);

    // Bounce on 'w': 1,0,1 then hold
    rearm();
    c0 = cyc;
    w = 1'b1; tick(1);
    w = 1'b0; tick(1);
    w = 1'b1;
    push(0, 1, c0 + 8);
    tick(20);
    w = 1'b0;
    tick(10);
    chk("bounce_drain", sb.size(), 0);

    // Chord q+s ignored, then release q leaving s
    rearm();
    q = 1'b1; s = 1'b1;
    tick(30);
    chk("chord_no_pulse", sb.size(), 0);
    q = 1'b0;
    push(0, 3, cyc + DC + 2);
    tick(10);
    s = 1'b0;
    tick(10);
    chk("chord_drain", sb.size(), 0);

    // Timeout with no keys
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    push(1, 0, cyc + TC + 1);
    tick(TC + 5);
    chk("timeout_ready_low", int'(ready), 0);
    chk("timeout_drain", sb.size(), 0);
    rearm();
    c0 = cyc;
    q = 1'b1;
    push(0, 0, c0 + DC + 2);
    tick(10);
    q = 1'b0;
    tick(10);
    chk("rearm_drain", sb.size(), 0);

    // Hold 's' for 100 cycles, early re-press during release debounce, then proper press of 'q'
    rearm();
    c0 = cyc;
    s = 1'b1;
    push(0, 3, c0 + DC + 2);
    tick(100);
    s = 1'b0;
    tick(3);
    q = 1'b1;             // lands in release debounce: must not be accepted
    tick(10);
    q = 1'b0;
    tick(DC + 2);
    q = 1'b1;
    push(0, 0, cyc + DC + 2);
    tick(10);
    q = 1'b0;
    tick(10);
    chk("hold_drain", sb.size(), 0);

    // Reset during press debounce
    rearm();
    a = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("rstab_tile", int'(tile), 0);
    chk("rstab_tile_valid", int'(tile_valid), 0);
    chk("rstab_ready", int'(ready), 0);
    chk("rstab_key_held", int'(key_held), 0);
    chk("rstab_timeout", int'(timeout), 0);
    reset = 1'b0;
    a = 1'b0;
    tick(10);
    chk("rstab_drain", sb.size(), 0);

    // enable drops exactly at the acceptance edge
    rearm();
    a = 1'b1;
    tick(DC + 1);
    enable = 1'b0;
    tick(3);
    a = 1'b0;
    tick(5);
    chk("enab_ready_low", int'(ready), 0);
    chk("enab_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_input_encoder.md
# player_input_encoder

Turns the raw q/w/a/s key levels from `keyboard_tracker` into clean, single-shot tile selections for `player`. It sits between the two. Each key level is debounced, and a press is accepted only when exactly one key is held. Each accepted press yields one `tile_valid` pulse carrying a 2-bit tile code. The block also detects when the player fails to respond within a time limit.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of cycles a key pattern must be stable before a press or release is accepted (10 ms at 50 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, default 250000000: number of cycles to wait for a press before `timeout` fires (5 s); must be > `DEBOUNCE_CYCLES`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, `CLOCK_50`.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  input window open, driven by control `playerEN`.
- `q`, `w`, `a`, `s`  in  1 each  key-held levels from `keyboard_tracker`, same clock domain.
- `tile`  out  2  code of the last accepted press: q=0, w=1, a=2, s=3.
- `tile_valid`  out  1  one-cycle pulse when a press is accepted.
- `timeout`  out  1  one-cycle pulse when no press is accepted in time.
- `ready`  out  1  high when waiting for a press (state WAIT_PRESS).
- `key_held`  out  1  high while an accepted key is still held (states WAIT_RELEASE and DEBOUNCE_RELEASE); drives the tile flash.

## Operation
- Inputs are registered once into `k_r[3:0]` = {s,a,w,q}. All decisions use `k_r`.
- States:
  - IDLE
  - WAIT_PRESS
  - DEBOUNCE_PRESS
  - WAIT_RELEASE
  - DEBOUNCE_RELEASE
  - TIMED_OUT
- Registers: debounce counter `dcnt` and timeout counter `tcnt`, each sized to its parameter.
- IDLE: when `enable`=1, go to WAIT_PRESS and clear `tcnt`.
- WAIT_PRESS:
  - If `k_r` is one-hot, latch the pattern, clear `dcnt`, and go to DEBOUNCE_PRESS.
  - A zero pattern or multiple keys held are ignored.
- DEBOUNCE_PRESS:
  - If `k_r` differs from the latched pattern, return to WAIT_PRESS.
  - Otherwise increment `dcnt`.
  - When `dcnt`==`DEBOUNCE_CYCLES`-1 and the pattern still matches: register `tile`, pulse `tile_valid`, and go to WAIT_RELEASE.
- WAIT_RELEASE: when `k_r`==0, clear `dcnt` and go to DEBOUNCE_RELEASE.
- DEBOUNCE_RELEASE:
  - If any key is seen, return to WAIT_RELEASE. This stops a long hold or bounce from producing a second pulse.
  - When `dcnt`==`DEBOUNCE_CYCLES`-1 with `k_r`==0, clear `tcnt` and go to WAIT_PRESS.
- `tcnt` increments every cycle in WAIT_PRESS and DEBOUNCE_PRESS. It does not reset when a debounce attempt is aborted.
- When `tcnt`==`TIMEOUT_CYCLES`-1, pulse `timeout` and go to TIMED_OUT.
- TIMED_OUT holds until `enable`=0.
- `enable`=0 in any state: go to IDLE on the next edge and emit no pulse.
- `tile` keeps its value while in IDLE.

## Timing
- Reset values: state=IDLE, `tile`=0, `tile_valid`=0, `timeout`=0, `ready`=0, `key_held`=0, `k_r`=0, `dcnt`=0, `tcnt`=0.
- All outputs are registered.
- Press latency: `tile_valid` is high exactly at cycle `DEBOUNCE_CYCLES`+2, where cycle 0 is the first cycle the single key is high at the input with the block in WAIT_PRESS.
- `tile` changes in the same cycle `tile_valid` rises, then holds.
- Release: a new press can be accepted no earlier than `DEBOUNCE_CYCLES`+2 cycles after all keys drop.
- Simultaneous acceptance and timeout on the same edge: acceptance wins. `tile_valid` pulses, `timeout` does not.
- `enable` falling on the same edge as an acceptance or timeout: neither pulse fires.
- Reset mid-debounce: state returns to IDLE the next cycle and no pulse is emitted.
- At most one of `tile_valid` and `timeout` is high in any cycle.
- Each pulse is exactly one cycle wide.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=50, and `enable`=1 unless stated.
- Clean press: hold `a` from cycle 0 for 20 cycles -> `tile_valid`=1 only at cycle 6 with `tile`=2; `key_held`=1 from cycle 7 until 4+ cycles after release.
- Bounce: toggle `w` 1,0,1 on cycles 0–2, then hold it -> the abort returns to WAIT_PRESS; `tile_valid` fires once, at cycle 8, with `tile`=1.
- Chord: hold `q`+`s` together for 30 cycles -> no `tile_valid`; releasing `q` while still holding `s` -> one pulse with `tile`=3.
- Timeout: no keys pressed after entering WAIT_PRESS -> `timeout` pulses once, 50 cycles later; `ready`=0 afterwards; dropping `enable` then raising it re-arms the block, and a later press is accepted normally.
- Hold and repeat: hold `s` for 100 cycles -> exactly one `tile_valid`; release, then press `q` -> a second pulse with `tile`=0 at least 6 cycles after the release.
- Reset and enable abort: assert `reset` at cycle 3 of DEBOUNCE_PRESS -> all outputs are 0 next cycle and no pulse follows; separately, drop `enable` at the acceptance edge -> no pulse.
